// File: rtl/syn_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage of the MIPS core.
// Holds the reset PC, the NOP encoding and the fetch FSM state type.
package syn_fetch_stage_pkg;

    localparam logic [31:0] FETCH_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] INST_NOP       = 32'h0000_0000;
    localparam int          FETCH_ST_BIT   = 1;

    typedef enum logic [FETCH_ST_BIT-1:0] {
        FETCH_ST_RUN  = 1'b0,
        FETCH_ST_HALT = 1'b1
    } fetch_st_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/syn_fetch_next_pc.sv
// Combinational next-address selection for instruction fetch plus the
// sequential-PC adders for the chosen address and the word currently in ID.
module syn_fetch_next_pc
    import syn_fetch_stage_pkg::*;
(
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        f_valid,
    input  logic [31:0] pc,
    input  logic [31:0] fpc,
    output logic [31:0] next_addr,
    output logic [31:0] next_addr_p4,
    output logic [31:0] fpc_p4
);

    // A stalled valid word is re-read so im_data keeps presenting it.
    always_comb begin
        next_addr = pc;
        if (redirect) begin
            next_addr = word_align(redirect_pc);
        end else if (stall && f_valid) begin
            next_addr = fpc;
        end
    end

    assign next_addr_p4 = next_addr + 32'd4;
    assign fpc_p4       = fpc + 32'd4;

endmodule

// File: rtl/syn_fetch_stage.sv
// Instruction-fetch stage and IF/ID boundary: PC sequencing, redirect/stall/halt
// handling and a count of instructions accepted by decode.
module syn_fetch_stage
    import syn_fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = FETCH_PC_RESET,
    parameter int          IM_ADDR_BIT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt,
    output logic [IM_ADDR_BIT-1:0] im_addr,
    input  logic [31:0]            im_data,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_pc4,
    output logic [31:0]            id_inst,
    output logic [5:0]             id_opcode,
    output logic [4:0]             id_rt,
    output logic [5:0]             id_funct,
    output logic                   halted,
    output logic [31:0]            fetch_count
);

    fetch_st_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fpc_q, fpc_d;
    logic        f_valid_q, f_valid_d;
    logic        count_inc;
    logic [31:0] next_addr, next_addr_p4, fpc_p4;

    syn_fetch_next_pc u_next_pc (
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .f_valid      (f_valid_q),
        .pc           (pc_q),
        .fpc          (fpc_q),
        .next_addr    (next_addr),
        .next_addr_p4 (next_addr_p4),
        .fpc_p4       (fpc_p4)
    );

    assign im_addr = next_addr[IM_ADDR_BIT+1:2];

    // Redirect and plain advance both load next_addr: without a redirect or a
    // valid stall the mux already selects pc, so fpc<=pc and pc<=pc+4 fall out.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fpc_d     = fpc_q;
        f_valid_d = f_valid_q;
        count_inc = 1'b0;
        if (en && state_q == FETCH_ST_RUN) begin
            if (halt) begin
                state_d   = FETCH_ST_HALT;
                f_valid_d = 1'b0;
            end else if (redirect || !(stall && f_valid_q)) begin
                fpc_d     = next_addr;
                pc_d      = next_addr_p4;
                f_valid_d = 1'b1;
            end
            count_inc = id_valid && !stall && !redirect && !halt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_ST_RUN;
            pc_q        <= PC_RESET;
            fpc_q       <= PC_RESET;
            f_valid_q   <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fpc_q       <= fpc_d;
            f_valid_q   <= f_valid_d;
            fetch_count <= fetch_count + {31'd0, count_inc};
        end
    end

    assign halted    = (state_q == FETCH_ST_HALT);
    assign id_valid  = f_valid_q && (state_q == FETCH_ST_RUN);
    assign id_pc     = fpc_q;
    assign id_pc4    = fpc_p4;
    assign id_inst   = id_valid ? im_data : INST_NOP;
    assign id_opcode = id_inst[31:26];
    assign id_rt     = id_inst[20:16];
    assign id_funct  = id_inst[5:0];

endmodule

// File: tb/tb_syn_fetch_stage.sv
// Directed bench for syn_fetch_stage with a 1-cycle synchronous instruction memory.
module tb_syn_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, en, stall, redirect, halt;
    logic [31:0] redirect_pc;
    logic [9:0]  im_addr;
    logic [31:0] im_data;
    logic        id_valid, halted;
    logic [31:0] id_pc, id_pc4, id_inst, fetch_count;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rt;

    int checks = 0;
    int failures = 0;

    logic [31:0] imem [1024];

    syn_fetch_stage #(.PC_RESET(32'h0000_3000), .IM_ADDR_BIT(10)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .im_addr(im_addr), .im_data(im_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .id_opcode(id_opcode), .id_rt(id_rt), .id_funct(id_funct),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // The memory read port freezes together with the core's global enable.
    always @(posedge clk) if (en) im_data <= imem[im_addr];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 32'h0;
        cyc(); cyc();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=00000000", id_inst); end
        checks++; if (id_pc !== 32'h3000) begin failures++; $display("FAIL rst_pc got=%h exp=00003000", id_pc); end
        checks++; if (id_pc4 !== 32'h3004) begin failures++; $display("FAIL rst_pc4 got=%h exp=00003004", id_pc4); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
        checks++; if (im_addr !== 10'h000) begin failures++; $display("FAIL rst_imaddr got=%h exp=000", im_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        cyc();
        checks++; if (id_pc !== 32'h3000) begin failures++; $display("FAIL seq1_pc got=%h exp=00003000", id_pc); end
        checks++; if (id_opcode !== 6'h08) begin failures++; $display("FAIL seq1_opcode got=%h exp=08", id_opcode); end
        checks++; if (id_rt !== 5'h08) begin failures++; $display("FAIL seq1_rt got=%h exp=08", id_rt); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq1_valid got=%0h exp=1", id_valid); end
        cyc();
        checks++; if (id_pc !== 32'h3004) begin failures++; $display("FAIL seq2_pc got=%h exp=00003004", id_pc); end
        checks++; if (id_funct !== 6'h0C) begin failures++; $display("FAIL seq2_funct got=%h exp=0c", id_funct); end
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL seq2_count got=%0d exp=1", fetch_count); end
        cyc();
        checks++; if (id_pc !== 32'h3008) begin failures++; $display("FAIL seq3_pc got=%h exp=00003008", id_pc); end
        checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL seq3_count got=%0d exp=2", fetch_count); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++; if (im_addr !== 10'h002) begin failures++; $display("FAIL stall_imaddr0 got=%h exp=002", im_addr); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (id_pc !== 32'h3008) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=00003008", i, id_pc); end
            checks++; if (id_inst !== 32'h1000_0002) begin failures++; $display("FAIL stall_inst[%0d] got=%h exp=10000002", i, id_inst); end
            checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, fetch_count); end
            checks++; if (im_addr !== 10'h002) begin failures++; $display("FAIL stall_imaddr[%0d] got=%h exp=002", i, im_addr); end
        end
        stall = 1'b0;
        cyc();
        checks++; if (id_pc !== 32'h300C) begin failures++; $display("FAIL unstall_pc got=%h exp=0000300c", id_pc); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL unstall_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3043;
        #1;
        checks++; if (im_addr !== 10'h010) begin failures++; $display("FAIL redir_imaddr got=%h exp=010", im_addr); end
        cyc();
        stall = 1'b0; redirect = 1'b0;
        #1;
        checks++; if (id_pc !== 32'h3040) begin failures++; $display("FAIL redir_pc got=%h exp=00003040", id_pc); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%0h exp=1", id_valid); end
        checks++; if (id_inst !== 32'h1000_0010) begin failures++; $display("FAIL redir_inst got=%h exp=10000010", id_inst); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
        checks++; if (im_addr !== 10'h011) begin failures++; $display("FAIL redir_nextpc got=%h exp=011", im_addr); end
        cyc();
        checks++; if (id_pc !== 32'h3044) begin failures++; $display("FAIL redir2_pc got=%h exp=00003044", id_pc); end
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL redir2_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (id_pc !== 32'h3044) begin failures++; $display("FAIL en_pc[%0d] got=%h exp=00003044", i, id_pc); end
            checks++; if (id_inst !== 32'h1000_0011) begin failures++; $display("FAIL en_inst[%0d] got=%h exp=10000011", i, id_inst); end
            checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL en_count[%0d] got=%0d exp=4", i, fetch_count); end
        end
        en = 1'b1;
        cyc();
        checks++; if (id_pc !== 32'h3048) begin failures++; $display("FAIL en_resume_pc got=%h exp=00003048", id_pc); end
        checks++; if (id_inst !== 32'h1000_0012) begin failures++; $display("FAIL en_resume_inst got=%h exp=10000012", id_inst); end
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL en_resume_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_pc = 32'h0000_3010;
        cyc();
        redirect = 1'b0;
        checks++; if (id_pc !== 32'h3010) begin failures++; $display("FAIL hredir_pc got=%h exp=00003010", id_pc); end
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%0h exp=1", halted); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%0h exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL halt_inst got=%h exp=00000000", id_inst); end
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL halt_count got=%0d exp=5", fetch_count); end
        redirect = 1'b1; redirect_pc = 32'h0000_3100;
        cyc(); cyc();
        redirect = 1'b0;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%0h exp=1", halted); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halt_redir_valid got=%0h exp=0", id_valid); end
        checks++; if (id_pc !== 32'h3010) begin failures++; $display("FAIL halt_redir_pc got=%h exp=00003010", id_pc); end
        #2 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL arst_halted got=%0h exp=0", halted); end
        checks++; if (id_pc !== 32'h3000) begin failures++; $display("FAIL arst_pc got=%h exp=00003000", id_pc); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", fetch_count); end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        checks++; if (id_pc !== 32'h3000) begin failures++; $display("FAIL post_rst_pc got=%h exp=00003000", id_pc); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%0h exp=1", id_valid); end
        checks++; if (id_inst !== 32'h2008_0005) begin failures++; $display("FAIL post_rst_inst got=%h exp=20080005", id_inst); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (im_addr !== 10'h3FF) begin failures++; $display("FAIL wrap_imaddr0 got=%h exp=3ff", im_addr); end
        cyc();
        redirect = 1'b0;
        #1;
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", id_pc); end
        checks++; if (id_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=00000000", id_pc4); end
        checks++; if (id_inst !== 32'h1000_03FF) begin failures++; $display("FAIL wrap_inst got=%h exp=100003ff", id_inst); end
        checks++; if (im_addr !== 10'h000) begin failures++; $display("FAIL wrap_imaddr1 got=%h exp=000", im_addr); end
        cyc();
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL wrap2_pc got=%h exp=00000000", id_pc); end
        checks++; if (id_pc4 !== 32'h4) begin failures++; $display("FAIL wrap2_pc4 got=%h exp=00000004", id_pc4); end
        checks++; if (id_inst !== 32'h2008_0005) begin failures++; $display("FAIL wrap2_inst got=%h exp=20080005", id_inst); end
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL wrap2_count got=%0d exp=1", fetch_count); end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) imem[k] = 32'h1000_0000 | k;
        imem[0] = 32'h2008_0005;
        imem[1] = 32'h0000_000C;
        im_data = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_enable();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
